// File: rtl/pc_sequencer.sv
// Program-counter front-end controller: next-PC selection, load-use stalls,
// branch/jump redirects (deferred across instruction-memory waits), event counters.
module pc_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_cur,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  input  logic             im_wait,
  output logic [31:0]      pc_next,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redir_cnt
);

  typedef enum logic [1:0] {RUN, HOLD, PEND} state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] pend_target;
  logic [31:0] aligned_target;
  logic [31:0] seq_pc;
  logic        hz;
  logic        run_eval;
  logic        freeze;
  logic        capture;
  logic        redir_inc;

  assign aligned_target = ex_target & 32'hFFFF_FFFC;
  assign seq_pc         = pc_cur + 32'd4;
  assign hz = ex_memread && (ex_rd != 5'd0) &&
              ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pend_target <= 32'd0;
      stall_cnt   <= '0;
      redir_cnt   <= '0;
    end else begin
      state <= next_state;
      if (capture)
        pend_target <= aligned_target;
      if (pc_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (redir_inc && (redir_cnt != '1))
        redir_cnt <= redir_cnt + CNT_W'(1);
    end
  end

  // HOLD falls through to the RUN rules in the cycle the wait clears,
  // so a hazard in that same cycle still stalls.
  always_comb begin
    next_state = state;
    pc_next    = seq_pc;
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    run_eval   = 1'b0;
    freeze     = 1'b0;
    capture    = 1'b0;
    redir_inc  = 1'b0;

    unique case (state)
      RUN: run_eval = 1'b1;
      HOLD: begin
        if (ex_redirect) begin
          freeze     = 1'b1;
          capture    = 1'b1;
          next_state = PEND;
        end else if (im_wait) begin
          freeze = 1'b1;
        end else begin
          next_state = RUN;
          run_eval   = 1'b1;
        end
      end
      PEND: begin
        if (im_wait) begin
          freeze = 1'b1;
        end else begin
          pc_next    = pend_target;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          redir_inc  = 1'b1;
          next_state = RUN;
        end
      end
      default: next_state = RUN;
    endcase

    if (run_eval) begin
      if (ex_redirect && im_wait) begin
        freeze     = 1'b1;
        capture    = 1'b1;
        next_state = PEND;
      end else if (ex_redirect) begin
        pc_next    = aligned_target;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        redir_inc  = 1'b1;
      end else if (im_wait) begin
        freeze     = 1'b1;
        next_state = HOLD;
      end else if (hz) begin
        freeze = 1'b1;
      end
    end

    if (freeze) begin
      pc_next    = pc_cur;
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end

    // Reset flushes the pipeline and lets fetch run sequentially.
    if (rst) begin
      pc_next    = seq_pc;
      pc_stall   = 1'b0;
      ifid_stall = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed cycles push expected outputs,
// a monitor pops and compares them mid-cycle.
module tb_pc_sequencer;

  localparam int CNT_W = 4;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic [4:0]  rd;
    logic        mr;
    logic        redir;
    logic [31:0] tgt;
    logic        w;
  } stim_t;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [3:0]  ctrl;
    logic [3:0]  sc;
    logic [3:0]  rc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      pc_cur = '0;
  logic [4:0]       id_rs1 = '0;
  logic [4:0]       id_rs2 = '0;
  logic             id_rs1_used = 1'b0;
  logic             id_rs2_used = 1'b0;
  logic [4:0]       ex_rd = '0;
  logic             ex_memread = 1'b0;
  logic             ex_redirect = 1'b0;
  logic [31:0]      ex_target = '0;
  logic             im_wait = 1'b0;
  logic [31:0]      pc_next;
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] redir_cnt;

  exp_t     q[$];
  int       tests = 0;
  int       failures = 0;
  int       m_stall = 0;
  int       m_redir = 0;

  pc_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_memread(ex_memread),
    .ex_redirect(ex_redirect), .ex_target(ex_target), .im_wait(im_wait),
    .pc_next(pc_next), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .stall_cnt(stall_cnt), .redir_cnt(redir_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic stim_t base(input logic [31:0] pc);
    stim_t s;
    s = '{rst: 1'b0, pc: pc, rs1: 5'd0, rs2: 5'd0, u1: 1'b0, u2: 1'b0, rd: 5'd0,
          mr: 1'b0, redir: 1'b0, tgt: 32'd0, w: 1'b0};
    return s;
  endfunction

  // ctrl = {pc_stall, ifid_stall, ifid_flush, idex_flush}
  task automatic applyStimulus(input string tag, input stim_t s, input logic [31:0] e_pc,
                               input logic [3:0] e_ctrl);
    exp_t e;
    @(negedge clk);
    rst = s.rst; pc_cur = s.pc; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_rs1_used = s.u1; id_rs2_used = s.u2; ex_rd = s.rd; ex_memread = s.mr;
    ex_redirect = s.redir; ex_target = s.tgt; im_wait = s.w;
    if (s.rst) begin
      m_stall = 0;
      m_redir = 0;
    end
    e = '{tag: tag, pc: e_pc, ctrl: e_ctrl, sc: 4'(m_stall), rc: 4'(m_redir)};
    q.push_back(e);
    if (!s.rst) begin
      if (e_ctrl[3] && m_stall < 15) m_stall++;
      if (e_ctrl[1] && m_redir < 15) m_redir++;
    end
  endtask

  // Asynchronous reset asserted mid-cycle, leaving the other inputs untouched.
  task automatic resetPulse(input string tag);
    exp_t e;
    @(negedge clk);
    #1 rst = 1'b1;
    m_stall = 0;
    m_redir = 0;
    e = '{tag: tag, pc: pc_cur + 32'd4, ctrl: 4'b0011, sc: 4'd0, rc: 4'd0};
    q.push_back(e);
  endtask

  always begin
    exp_t e;
    @(negedge clk);
    #3;
    if (q.size() > 0) begin
      e = q.pop_front();
      checkOutput({e.tag, ".pc_next"}, pc_next, e.pc);
      checkOutput({e.tag, ".ctrl"}, {28'd0, pc_stall, ifid_stall, ifid_flush, idex_flush},
                  {28'd0, e.ctrl});
      checkOutput({e.tag, ".stall_cnt"}, {28'd0, stall_cnt}, {28'd0, e.sc});
      checkOutput({e.tag, ".redir_cnt"}, {28'd0, redir_cnt}, {28'd0, e.rc});
    end
  end

  initial begin
    stim_t s;

    s = base(32'h100); s.rst = 1'b1;
    applyStimulus("reset", s, 32'h104, 4'b0011);
    applyStimulus("seq", base(32'h100), 32'h104, 4'b0000);
    applyStimulus("wrap", base(32'hFFFF_FFFC), 32'h0, 4'b0000);

    s = base(32'h108); s.mr = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1;
    applyStimulus("hz_rs1", s, 32'h108, 4'b1101);
    applyStimulus("hz_after", base(32'h108), 32'h10C, 4'b0000);
    s = base(32'h10C); s.mr = 1; s.rd = 5; s.rs1 = 3; s.u1 = 1; s.rs2 = 5; s.u2 = 1;
    applyStimulus("hz_rs2", s, 32'h10C, 4'b1101);
    s = base(32'h10C); s.mr = 1; s.rd = 0; s.rs1 = 0; s.u1 = 1;
    applyStimulus("hz_rd0", s, 32'h110, 4'b0000);
    s = base(32'h10C); s.mr = 1; s.rd = 7; s.rs1 = 7; s.u1 = 0;
    applyStimulus("hz_unused", s, 32'h110, 4'b0000);

    s = base(32'h110); s.redir = 1; s.tgt = 32'h203;
    applyStimulus("branch", s, 32'h200, 4'b0011);
    s.mr = 1; s.rd = 9; s.rs1 = 9; s.u1 = 1;
    applyStimulus("branch_hz", s, 32'h200, 4'b0011);

    s = base(32'h200); s.redir = 1; s.tgt = 32'h400; s.w = 1;
    applyStimulus("pend_cap", s, 32'h200, 4'b1101);
    s.tgt = 32'h800;
    applyStimulus("pend_ign", s, 32'h200, 4'b1101);
    s = base(32'h200); s.w = 1;
    applyStimulus("pend_wait", s, 32'h200, 4'b1101);
    applyStimulus("pend_apply", base(32'h200), 32'h400, 4'b0011);
    applyStimulus("pend_after", base(32'h400), 32'h404, 4'b0000);

    s = base(32'h404); s.w = 1;
    applyStimulus("hold", s, 32'h404, 4'b1101);
    s = base(32'h404); s.mr = 1; s.rd = 4; s.rs2 = 4; s.u2 = 1;
    applyStimulus("hold_hz", s, 32'h404, 4'b1101);
    applyStimulus("hold_run", base(32'h404), 32'h408, 4'b0000);

    s = base(32'h408); s.w = 1;
    applyStimulus("hold2", s, 32'h408, 4'b1101);
    s = base(32'h408); s.redir = 1; s.tgt = 32'h50A;
    applyStimulus("hold_redir", s, 32'h408, 4'b1101);
    applyStimulus("hold_apply", base(32'h408), 32'h508, 4'b0011);

    s = base(32'h200); s.redir = 1; s.tgt = 32'h400; s.w = 1;
    applyStimulus("rst_cap", s, 32'h200, 4'b1101);
    resetPulse("rst_async");
    applyStimulus("rst_release", base(32'h200), 32'h204, 4'b0000);
    applyStimulus("rst_after", base(32'h204), 32'h208, 4'b0000);

    s = base(32'h300); s.w = 1;
    for (int i = 0; i < 20; i++)
      applyStimulus($sformatf("sat%0d", i), s, 32'h300, 4'b1101);
    applyStimulus("sat_end", base(32'h300), 32'h304, 4'b0000);

    @(negedge clk);
    #5;
    checkOutput("drain", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
